// File: rtl/adder_arbiter_pkg.sv
// adder_arbiter_pkg
// Shared definitions for the two-requester adder arbiter:
//   - state_t       : arbiter FSM encoding (IDLE / EXEC / DONE)
//   - ADDER_WIDTH   : default operand width of the shared adder
//   - STAT_W        : width of the optional per-requester grant counters
//   - sat_inc()     : saturating increment used by the grant counters
package adder_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int ADDER_WIDTH = 10;
    localparam int STAT_W      = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/adder_arbiter_fa_chain.sv
// adder_arbiter_fa_chain
// Ripple-carry adder built from a chain of full adders. This is the single
// shared adder instance; only the arbiter drives its inputs.
// Ports:
//   a, b : WIDTH-bit operands
//   cin  : carry in
//   sum  : WIDTH-bit sum
//   cout : carry out of the most significant stage
module adder_arbiter_fa_chain #(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/adder_arbiter_rr_pick2.sv
// adder_arbiter_rr_pick2 (module rr_pick2)
// Combinational 2-way round-robin picker.
// Ports:
//   req0, req1  : request lines
//   last_owner  : requester served most recently (0 or 1)
//   gnt0, gnt1  : one-hot (or zero) pick; a tie goes to the requester
//                 that is not last_owner
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last_owner,
    output logic gnt0,
    output logic gnt1
);

    // A sole requester always wins; on a tie the one not served last wins.
    assign gnt0 = req0 & (~req1 |  last_owner);
    assign gnt1 = req1 & (~req0 | ~last_owner);

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter (top)
// Shares one WIDTH-bit adder between two requesters with round-robin
// arbitration. A granted request latches its operands, the adder runs for
// one cycle, and the (WIDTH+1)-bit sum is returned with a one-cycle done
// pulse to the owner. Grant in cycle N -> done in cycle N+2; one operation
// per three cycles.
//
// Ports:
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   req0, a0, b0      : requester 0 request and operands
//   gnt0, done0       : requester 0 grant (combinational) and done pulse
//   req1, a1, b1      : requester 1 request and operands
//   gnt1, done1       : requester 1 grant (combinational) and done pulse
//   result            : registered sum of the latched operands (carry in MSB)
//   busy              : high whenever the FSM is not in IDLE
//   state_dbg         : current FSM state, for observation
//   cnt0, cnt1        : saturating grant counters (only with the
//                       ADDER_ARB_STATS_EN macro defined)
//
// Handshake: a requester raises reqN with its operands and holds both until
// it sees gntN high; the operands are captured at the edge that ends the
// grant cycle, so they may change freely afterwards. Dropping reqN before
// gntN withdraws the request. doneN marks the single cycle in which result
// first carries that requester's sum; result then holds until the next
// operation's adder cycle.
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    output logic             gnt0,
    output logic             done0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt1,
    output logic             done1,
    output logic [WIDTH:0]   result,
    output logic             busy,
    output logic [1:0]       state_dbg
`ifdef ADDER_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] cnt0,
    output logic [STAT_W-1:0] cnt1
`endif
);

    state_t           state;
    logic             owner;
    logic             last_owner;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             pick0;
    logic             pick1;
    logic             arb_en;

    assign state_dbg = state;

    rr_pick2 u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_owner (last_owner),
        .gnt0       (pick0),
        .gnt1       (pick1)
    );

    // Arbitration only happens in IDLE, and reset suppresses any grant in
    // the same cycle.
    assign arb_en = (state == ST_IDLE) && !reset;
    assign gnt0   = arb_en & pick0;
    assign gnt1   = arb_en & pick1;

    // Carry-in tied low: the block only ever does plain a+b.
    adder_arbiter_fa_chain #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (op_a),
        .b    (op_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            op_a       <= '0;
            op_b       <= '0;
            result     <= '0;
            owner      <= 1'b0;
            last_owner <= 1'b1;   // requester 0 wins the first tie
            done0      <= 1'b0;
            done1      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    if (gnt0) begin
                        op_a       <= a0;
                        op_b       <= b0;
                        owner      <= 1'b0;
                        last_owner <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ST_EXEC;
                    end else if (gnt1) begin
                        op_a       <= a1;
                        op_b       <= b1;
                        owner      <= 1'b1;
                        last_owner <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ST_EXEC;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    result <= {add_cout, add_sum};
                    done0  <= ~owner;
                    done1  <= owner;
                    busy   <= 1'b1;
                    state  <= ST_DONE;
                end
                ST_DONE: begin
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ADDER_ARB_STATS_EN
    // Grant counters advance on the same edge that captures the operands.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (gnt0) cnt0 <= sat_inc(cnt0);
            if (gnt1) cnt1 <= sat_inc(cnt1);
        end
    end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter
// Self-checking bench for adder_arbiter. A transaction-level model predicts
// grants, done pulses, busy and result every cycle; directed scenarios add
// literal expectations (sums, grant order, latency, isolation, reset abort).
// Build with +define+ADDER_ARB_STATS_EN to also cover the grant counters.
module tb_adder_arbiter;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0, req1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         gnt0, gnt1, done0, done1, busy;
    logic [W:0]   result;
    logic [1:0]   state_dbg;
`ifdef ADDER_ARB_STATS_EN
    logic [7:0]   cnt0, cnt1;
`endif

    always #5 clk = ~clk;

    adder_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .a0        (a0),
        .b0        (b0),
        .gnt0      (gnt0),
        .done0     (done0),
        .req1      (req1),
        .a1        (a1),
        .b1        (b1),
        .gnt1      (gnt1),
        .done1     (done1),
        .result    (result),
        .busy      (busy),
        .state_dbg (state_dbg)
`ifdef ADDER_ARB_STATS_EN
        ,
        .cnt0      (cnt0),
        .cnt1      (cnt1)
`endif
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    logic [W:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_age counts cycles since the last accepted grant: 0 = free,
    // 1 = adding, 2 = answer due this cycle.
    bit   m_valid = 0;
    int   m_age;
    int   m_owner;
    int   m_last;
    int   m_pend;
    int   m_res;
    int   m_cnt0, m_cnt1;
    logic e_g0, e_g1;

    always @(negedge clk) begin
        if (m_valid) begin
            // Sole requester wins; on a tie the requester not served last wins.
            e_g0 = (m_age == 0) && !reset && req0 && (!req1 || m_last == 1);
            e_g1 = (m_age == 0) && !reset && req1 && (!req0 || m_last == 0);
            chk("gnt0", 32'(gnt0), 32'(e_g0));
            chk("gnt1", 32'(gnt1), 32'(e_g1));
            chk("busy", 32'(busy), 32'(m_age != 0));
            chk("done0", 32'(done0), 32'(m_age == 2 && m_owner == 0));
            chk("done1", 32'(done1), 32'(m_age == 2 && m_owner == 1));
            chk("result", 32'(result), 32'(m_res));
`ifdef ADDER_ARB_STATS_EN
            chk("cnt0", 32'(cnt0), 32'(m_cnt0));
            chk("cnt1", 32'(cnt1), 32'(m_cnt1));
`endif
            if (done0 || done1) begin
                if (exp_q.size() > 0) chk("sb_result", 32'(result), 32'(exp_q.pop_front()));
                else chk("sb_unexpected_done", 32'(1), 32'(0));
            end
        end
        // Advance the model across the coming edge.
        if (reset) begin
            m_valid = 1;
            m_age   = 0;
            m_res   = 0;
            m_owner = 0;
            m_last  = 1;
            m_cnt0  = 0;
            m_cnt1  = 0;
        end else if (m_valid) begin
            if (m_age == 0) begin
                if (e_g0) begin
                    m_pend = int'(a0) + int'(b0);
                    m_owner = 0; m_last = 0; m_age = 1;
                    if (m_cnt0 < 255) m_cnt0++;
                end else if (e_g1) begin
                    m_pend = int'(a1) + int'(b1);
                    m_owner = 1; m_last = 1; m_age = 1;
                    if (m_cnt1 < 255) m_cnt1++;
                end
            end else if (m_age == 1) begin
                m_res = m_pend;
                m_age = 2;
            end else begin
                m_age = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step();
        reset = 1'b0;
    endtask

    // One operation on requester k; optionally rewrite operand A in the
    // cycle after the grant to show it no longer matters.
    task automatic do_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W:0] exp_r, input bit change_a, input logic [W-1:0] new_a,
                         input string name);
        int g_cyc;
        bit got;
        exp_q.push_back(exp_r);
        if (k == 0) begin a0 = a; b0 = b; req0 = 1'b1; end
        else        begin a1 = a; b1 = b; req1 = 1'b1; end
        got = 0;
        g_cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((k == 0 && gnt0) || (k == 1 && gnt1)) begin
                got = 1;
                g_cyc = cyc;
                break;
            end
        end
        step();
        if (k == 0) begin req0 = 1'b0; if (change_a) a0 = new_a; end
        else        begin req1 = 1'b0; if (change_a) a1 = new_a; end
        if (!got) begin
            chk({name, "_grant_timeout"}, 32'(0), 32'(1));
            return;
        end
        got = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if ((k == 0 && done0) || (k == 1 && done1)) begin
                got = 1;
                break;
            end
        end
        chk({name, "_done_seen"}, 32'(got), 32'(1));
        if (got) begin
            chk({name, "_latency"}, 32'(cyc - g_cyc), 32'(2));
            chk({name, "_sum"}, 32'(result), 32'(exp_r));
        end
        step();
    endtask

    // ---------------- stimulus ----------------
    int tie_who[$];
    int tie_cyc[$];
    int n_grants;

    initial begin
        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        step();
        do_reset(3);
        @(negedge clk);
        chk("rst_result", 32'(result), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_state", 32'(state_dbg), 32'(0));
        step();

        // Single request and overflow cases.
        do_op(0, 10'd300, 10'd200, 11'd500, 0, '0, "single0");
        do_op(1, 10'd1023, 10'd1023, 11'd2046, 0, '0, "ovf_max");
        do_op(1, 10'd1023, 10'd1, 11'd1024, 0, '0, "ovf_carry");

        // Tie after reset: both held, expect 0,1,0,1 three cycles apart.
        do_reset(2);
        a0 = 10'd5; b0 = 10'd6; a1 = 10'd7; b1 = 10'd8;
        exp_q.push_back(11'd11); exp_q.push_back(11'd15);
        exp_q.push_back(11'd11); exp_q.push_back(11'd15);
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 40 && tie_who.size() < 4; i++) begin
            @(negedge clk);
            if (gnt0) begin tie_who.push_back(0); tie_cyc.push_back(cyc); end
            if (gnt1) begin tie_who.push_back(1); tie_cyc.push_back(cyc); end
            step();
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) step();
        chk("tie_grant_count", 32'(tie_who.size()), 32'(4));
        if (tie_who.size() == 4) begin
            chk("tie_order_0", 32'(tie_who[0]), 32'(0));
            chk("tie_order_1", 32'(tie_who[1]), 32'(1));
            chk("tie_order_2", 32'(tie_who[2]), 32'(0));
            chk("tie_order_3", 32'(tie_who[3]), 32'(1));
            for (int i = 1; i < 4; i++)
                chk("tie_spacing", 32'(tie_cyc[i] - tie_cyc[i-1]), 32'(3));
        end

        // Operand isolation: a0 rewritten after the grant.
        do_op(0, 10'd1, 10'd1, 11'd2, 1, 10'd999, "isolate");

        // Reset during EXEC abandons the operation.
        a0 = 10'd3; b0 = 10'd4; req0 = 1'b1;
        n_grants = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (gnt0) begin n_grants = 1; break; end
        end
        chk("abort_grant", 32'(n_grants), 32'(1));
        step();
        req0 = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("abort_exec_busy", 32'(busy), 32'(1));
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done0 | done1), 32'(0));
            if (i == 0) begin
                chk("abort_result", 32'(result), 32'(0));
                chk("abort_busy", 32'(busy), 32'(0));
            end
            step();
        end

        // Reset dominates a simultaneous request; request then completes.
        reset = 1'b1; req0 = 1'b1; a0 = 10'd20; b0 = 10'd22;
        @(negedge clk);
        chk("rst_blocks_gnt", 32'(gnt0), 32'(0));
        step();
        reset = 1'b0;
        do_op(0, 10'd20, 10'd22, 11'd42, 0, '0, "after_reset");

        // Back-to-back sole req0 operations (also saturates the counter).
        a0 = 10'd1; b0 = 10'd2; req0 = 1'b1;
        n_grants = 0;
        for (int i = 0; i < 1200 && n_grants < 300; i++) begin
            @(negedge clk);
            if (gnt0) begin
                n_grants++;
                exp_q.push_back(11'd3);
            end
            step();
        end
        req0 = 1'b0;
        repeat (4) step();
        chk("b2b_grants", 32'(n_grants), 32'(300));
`ifdef ADDER_ARB_STATS_EN
        @(negedge clk);
        chk("stat_cnt0_sat", 32'(cnt0), 32'(255));
        chk("stat_cnt1", 32'(cnt1), 32'(0));
        step();
        do_reset(1);
        @(negedge clk);
        chk("stat_cnt0_rst", 32'(cnt0), 32'(0));
        chk("stat_cnt1_rst", 32'(cnt1), 32'(0));
        step();
`endif

        repeat (2) step();
        chk("sb_drained", 32'(exp_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Hard stop in case a wait loop is ever mis-bounded.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
